// File: rtl/mac_sched_pkg.sv
// Shared types for the round-robin multiply-accumulate scheduler.
package mac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_C,
        WAIT,
        RESP
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// Pure combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic found;
    int   j;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mac_sched.sv
// Round-robin scheduler feeding one serial a*b+c datapath from N_REQ requesters,
// returning the tagged result or a timeout error.
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 15,
    localparam int IW     = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*3*W-1:0] req_ops,
    output logic [N_REQ-1:0]     gnt,
    output logic                 mac_validi,
    output logic [W-1:0]         mac_data,
    input  logic                 mac_valido,
    input  logic [W-1:0]         mac_result,
    output logic                 rsp_valid,
    output logic [IW-1:0]        rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  cur_id;
    logic [W-1:0]   op_b;
    logic [W-1:0]   op_c;
    logic [CW-1:0]  cnt;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Grant is shown in the same IDLE cycle the pick is taken, so the next
    // transaction can start right after RESP.
    assign gnt = (state == IDLE && !rst) ? arb_gnt : '0;

    // Bus outputs are registered one state ahead: while in SEND_x the word x is on mac_data.
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_id     <= '0;
            op_b       <= '0;
            op_c       <= '0;
            cnt        <= '0;
            mac_validi <= 1'b0;
            mac_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        cur_id     <= arb_idx;
                        op_b       <= req_ops[int'(arb_idx)*3*W + W   +: W];
                        op_c       <= req_ops[int'(arb_idx)*3*W + 2*W +: W];
                        mac_validi <= 1'b1;
                        mac_data   <= req_ops[int'(arb_idx)*3*W +: W];
                        ptr        <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        state      <= SEND_A;
                    end
                end
                SEND_A: begin
                    mac_data <= op_b;
                    state    <= SEND_B;
                end
                SEND_B: begin
                    mac_data <= op_c;
                    state    <= SEND_C;
                end
                SEND_C: begin
                    mac_validi <= 1'b0;
                    mac_data   <= '0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (mac_valido) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= mac_result;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_id    <= '0;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: behavioural a*b+c datapath on the mac_* side, with a
// round-robin reference model and latency expectations per transaction.
module tb_mac_sched;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 15;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N*3*W-1:0]   req_ops;
    logic [N-1:0]       gnt;
    logic               mac_validi;
    logic [W-1:0]       mac_data;
    logic               mac_valido;
    logic [W-1:0]       mac_result;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [W-1:0]       rsp_data;
    logic               rsp_err;

    logic [W-1:0] ops [N][3];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  mptr   = 0;
    bit  stub   = 1'b0;
    bit  spur   = 1'b0;

    mac_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ops    (req_ops),
        .gnt        (gnt),
        .mac_validi (mac_validi),
        .mac_data   (mac_data),
        .mac_valido (mac_valido),
        .mac_result (mac_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                req_ops[i*3*W + k*W +: W] = ops[i][k];
    end

    // Serial datapath: collects a, b, c and answers one cycle after c.
    logic [1:0]   dp_cnt;
    logic [W-1:0] dp_a, dp_b, dp_res;
    logic         dp_valid;
    always @(posedge clk) begin
        if (rst) begin
            dp_cnt   <= 2'd0;
            dp_valid <= 1'b0;
            dp_res   <= '0;
            dp_a     <= '0;
            dp_b     <= '0;
        end else begin
            dp_valid <= 1'b0;
            if (mac_validi) begin
                case (dp_cnt)
                    2'd0:    dp_a <= mac_data;
                    2'd1:    dp_b <= mac_data;
                    default: begin
                        dp_res   <= dp_a * dp_b + mac_data;
                        dp_valid <= !stub;
                    end
                endcase
                dp_cnt <= (dp_cnt == 2'd2) ? 2'd0 : dp_cnt + 2'd1;
            end
        end
    end
    assign mac_valido = dp_valid | spur;
    assign mac_result = spur ? 32'hDEAD_BEEF : dp_res;

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                ops[i][k] = $urandom;
    endtask

    // One full transaction for requester exp_id, observed from grant to response.
    task automatic serve(input int exp_id, input bit exp_err, output int g_out);
        int n;
        int g;
        int lowv;
        int exp_lat;
        logic [N-1:0] gbits;
        logic [N-1:0] one;
        logic [W-1:0] w0, w1, w2, wk, exp_data;
        #1;
        g_out = -1;
        n = 0;
        while (gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gnt == '0) begin
            errors++;
            $display("FAIL grant_wait: no gnt within 40 cycles, expected id %0d", exp_id);
            return;
        end
        g = cyc;
        gbits = gnt;
        one = 1;
        checks++;
        if (gbits !== (one << exp_id)) begin
            errors++;
            $display("FAIL gnt: got %b expected %b", gbits, one << exp_id);
        end
        mptr = (exp_id + 1) % N;
        w0 = ops[exp_id][0];
        w1 = ops[exp_id][1];
        w2 = ops[exp_id][2];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) req = req & ~gbits;
            wk = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            checks++;
            if (mac_validi !== 1'b1 || mac_data !== wk) begin
                errors++;
                $display("FAIL operand%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, mac_validi, mac_data, wk);
            end
        end
        exp_data = exp_err ? '0 : w0 * w1 + w2;
        exp_lat  = exp_err ? 4 + TO : 5;
        n = 0;
        lowv = 0;
        do begin
            @(negedge clk);
            n++;
            if (mac_validi !== 1'b0) lowv++;
        end while (!rsp_valid && n < TO + 8);
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles for id %0d", TO + 8, exp_id);
            return;
        end
        checks++;
        if (cyc - g != exp_lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d expected %0d", cyc - g, exp_lat);
        end
        checks++;
        if ({rsp_id, rsp_err, rsp_data} !== {IW'(exp_id), exp_err, exp_data}) begin
            errors++;
            $display("FAIL rsp_fields: got id=%0d err=%b data=%h expected id=%0d err=%b data=%h",
                     rsp_id, rsp_err, rsp_data, exp_id, exp_err, exp_data);
        end
        checks++;
        if (lowv != 0) begin
            errors++;
            $display("FAIL validi_gap: mac_validi high %0d times after c, expected 0", lowv);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_valid still %b one cycle later, expected 0", rsp_valid);
        end
        g_out = g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, mac_validi, mac_data, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b validi=%b data=%h rsp_valid=%b id=%0d rdata=%h err=%b expected all 0",
                     gnt, mac_validi, mac_data, rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        req = '0;
        rst = 1'b0;
        mptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int g;
        ops[0][0] = 32'd3;
        ops[0][1] = 32'd4;
        ops[0][2] = 32'd5;
        req = 4'b0001;
        serve(0, 1'b0, g);
        checks++;
        if (rsp_data !== '0 || dp_res !== 32'd17) begin
            errors++;
            $display("FAIL single_result: datapath result %0d expected 17", dp_res);
        end
    endtask

    task automatic test_all_four();
        int g [4];
        do_reset();
        rand_ops();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve(i, 1'b0, g[i]);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (g[i] - g[i-1] != 6) begin
                errors++;
                $display("FAIL grant_spacing%0d: got %0d expected 6", i, g[i] - g[i-1]);
            end
        end
    endtask

    task automatic test_wrap();
        int g;
        rand_ops();
        req = 4'b0100;
        serve(2, 1'b0, g);
        req = 4'b1011;
        serve(3, 1'b0, g);
        serve(0, 1'b0, g);
        serve(1, 1'b0, g);
    endtask

    task automatic test_timeout();
        int g;
        rand_ops();
        stub = 1'b1;
        req = 4'b0010;
        serve(1, 1'b1, g);
        stub = 1'b0;
    endtask

    task automatic test_random();
        int g;
        int e;
        logic [N-1:0] mask;
        for (int r = 0; r < 6; r++) begin
            rand_ops();
            mask = N'($urandom_range(1, 15));
            req = mask;
            while (mask != '0) begin
                e = rr_pick(mask, mptr);
                serve(e, 1'b0, g);
                mask[e] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        int n;
        int bad;
        rand_ops();
        req = 4'b0100;
        #1;
        n = 0;
        while (gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (mac_validi !== 1'b1 || mac_data !== ops[2][1]) begin
            errors++;
            $display("FAIL mid_send_b: got valid=%b data=%h expected valid=1 data=%h",
                     mac_validi, mac_data, ops[2][1]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, mac_validi, mac_data, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: validi=%b data=%h rsp_valid=%b expected all 0",
                     mac_validi, mac_data, rsp_valid);
        end
        rst = 1'b0;
        mptr = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mac_validi !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dropped_txn: %0d cycles of activity after reset, expected 0", bad);
        end
        req = 4'b1010;
        serve(1, 1'b0, g);
    endtask

    task automatic test_overflow_spurious();
        int g;
        int bad;
        req = '0;
        bad = 0;
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        spur = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spurious_valido: rsp_valid seen %0d times, expected 0", bad);
        end
        ops[0][0] = 32'hFFFF_FFFF;
        ops[0][1] = 32'hFFFF_FFFF;
        ops[0][2] = 32'd2;
        req = 4'b0001;
        serve(0, 1'b0, g);
        checks++;
        if (dp_res !== 32'h0000_0003) begin
            errors++;
            $display("FAIL overflow: datapath result %h expected 00000003", dp_res);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                ops[i][k] = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_timeout();
        test_random();
        test_reset_mid();
        test_overflow_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
